// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with a registered divided clock and tick enable.
// Optional clock gating via the PROG_CLOCK_DIVIDER_GATE_EN macro (adds the enable input).
module prog_clock_divider #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RESET_DIV = 3
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_value,
`ifdef PROG_CLOCK_DIVIDER_GATE_EN
  input  logic             enable,
`endif
  output logic             div_ready,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  localparam int unsigned     CW      = DIV_W + 1;
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(RESET_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             run_c;
  logic             wrap_c;
  logic             accept_c;
  logic [DIV_W-1:0] new_div_c;
  logic [DIV_W-1:0] cnt_inc_c;
  logic [CW-1:0]    half_c;

`ifdef PROG_CLOCK_DIVIDER_GATE_EN
  assign run_c = enable;
`else
  assign run_c = 1'b1;
`endif

  // Next phase, divisor and output values; outputs derive from the next count.
  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_v_d   = pend_v_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    wrap_c    = (cnt_q == DIV_W'(cur_div_q - DIV_W'(1)));
    accept_c  = div_valid && !pend_v_q;
    new_div_c = pend_v_q ? pend_div_q : cur_div_q;
    cnt_inc_c = DIV_W'(cnt_q + DIV_W'(1));
    half_c    = CW'(({1'b0, cur_div_q} + CW'(1)) >> 1);

    if (wrap_c) begin
      // Period boundary: pending divisor lands here, whether running or parking.
      cur_div_d = new_div_c;
      pend_v_d  = 1'b0;
      if (run_c) begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end else begin
        cnt_d     = DIV_W'(new_div_c - DIV_W'(1));
        clk_out_d = 1'b0;
      end
    end else begin
      cnt_d     = cnt_inc_c;
      clk_out_d = ({1'b0, cnt_inc_c} < half_c);
    end

    // Only accepted while nothing is pending, so it never collides with the apply above.
    if (accept_c) begin
      pend_div_d = (div_value == '0) ? DIV_W'(1) : div_value;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt_q      <= RST_CNT;
      cur_div_q  <= RST_DIV;
      pend_div_q <= RST_DIV;
      pend_v_q   <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_v_q   <= pend_v_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign div_ready = ~pend_v_q;
  assign cur_div   = cur_div_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (default build, RESET_DIV=3).
module tb_prog_clock_divider;

  localparam int unsigned DIV_W = 8;

  logic             clk_in;
  logic             reset_n;
  logic             div_valid;
  logic [DIV_W-1:0] div_value;
  logic             div_ready;
  logic [DIV_W-1:0] cur_div;
  logic             clk_out;
  logic             tick;
`ifdef PROG_CLOCK_DIVIDER_GATE_EN
  logic             enable;
  initial enable = 1'b1;
`endif

  int total;
  int bad;

  prog_clock_divider #(.DIV_W(DIV_W), .RESET_DIV(3)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .div_valid (div_valid),
    .div_value (div_value),
`ifdef PROG_CLOCK_DIVIDER_GATE_EN
    .enable    (enable),
`endif
    .div_ready (div_ready),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clk_in edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic c, input logic t);
    step();
    chk({tag, "_clk"}, 32'(clk_out), 32'(c));
    chk({tag, "_tick"}, 32'(tick), 32'(t));
  endtask

  // Run n cycles; bit i of cpat/tpat is the expected clk_out/tick after the i-th edge.
  task automatic pat(input string tag, input int n, input logic [31:0] cpat, input logic [31:0] tpat);
    for (int i = 0; i < n; i++) begin
      step_chk($sformatf("%s%0d", tag, i), cpat[i], tpat[i]);
    end
  endtask

  task automatic offer(input logic [DIV_W-1:0] v);
    div_valid = 1'b1;
    div_value = v;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    div_valid = 1'b0;
    div_value = '0;

    // Reset state
    repeat (3) step();
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cur", 32'(cur_div), 32'd3);
    chk("rst_rdy", 32'(div_ready), 32'd1);

    // Free run at N=3: 1,1,0 with tick on the first edge
    reset_n = 1'b1;
    pat("n3_", 6, 32'b011011, 32'b001001);

    // Offer 6 exactly on the wrap cycle of N=3 (cnt=2)
    offer(8'd6);
    step_chk("w6a", 1'b1, 1'b1);
    chk("w6a_cur", 32'(cur_div), 32'd3);
    chk("w6a_rdy", 32'(div_ready), 32'd0);
    div_valid = 1'b0;
    pat("w6b_", 2, 32'b01, 32'b00);
    chk("w6b_cur", 32'(cur_div), 32'd3);
    chk("w6b_rdy", 32'(div_ready), 32'd0);
    step_chk("w6c", 1'b1, 1'b1);
    chk("w6c_cur", 32'(cur_div), 32'd6);
    chk("w6c_rdy", 32'(div_ready), 32'd1);
    pat("n6_", 6, 32'b100011, 32'b100000);

    // Offer 4 at cnt=0 of N=6: rest of the 6-period, then N=4 (2/2)
    offer(8'd4);
    step_chk("w4a", 1'b1, 1'b0);
    chk("w4a_rdy", 32'(div_ready), 32'd0);
    div_valid = 1'b0;
    pat("w4b_", 4, 32'b0001, 32'b0000);
    chk("w4b_cur", 32'(cur_div), 32'd6);
    step_chk("w4c", 1'b1, 1'b1);
    chk("w4c_cur", 32'(cur_div), 32'd4);
    pat("n4_", 7, 32'b0011001, 32'b0001000);

    // 7 on wrap, then 2 offered while 7 is pending
    offer(8'd7);
    step_chk("p7a", 1'b1, 1'b1);
    chk("p7a_cur", 32'(cur_div), 32'd4);
    offer(8'd2);
    pat("p7b_", 3, 32'b001, 32'b000);
    chk("p2_stall_rdy", 32'(div_ready), 32'd0);
    chk("p2_stall_cur", 32'(cur_div), 32'd4);
    step_chk("p7c", 1'b1, 1'b1);
    chk("p7c_cur", 32'(cur_div), 32'd7);
    chk("p7c_rdy", 32'(div_ready), 32'd1);
    step_chk("p2a", 1'b1, 1'b0);
    chk("p2a_rdy", 32'(div_ready), 32'd0);
    div_valid = 1'b0;
    pat("n7_", 5, 32'b00011, 32'b00000);
    chk("n7_cur", 32'(cur_div), 32'd7);
    step_chk("p2c", 1'b1, 1'b1);
    chk("p2c_cur", 32'(cur_div), 32'd2);
    chk("p2c_rdy", 32'(div_ready), 32'd1);

    // Zero request becomes N=1: constant high, tick every cycle
    offer(8'd0);
    step_chk("z0a", 1'b0, 1'b0);
    div_valid = 1'b0;
    step_chk("z0b", 1'b1, 1'b1);
    chk("z0b_cur", 32'(cur_div), 32'd1);
    pat("n1_", 3, 32'b111, 32'b111);

    // From N=1 to N=5 (3 high / 2 low)
    offer(8'd5);
    step_chk("w5a", 1'b1, 1'b1);
    chk("w5a_cur", 32'(cur_div), 32'd1);
    div_valid = 1'b0;
    step_chk("w5b", 1'b1, 1'b1);
    chk("w5b_cur", 32'(cur_div), 32'd5);
    pat("n5_", 5, 32'b10011, 32'b10000);

    // Reset mid-high with 9 pending: pending discarded, back to N=3
    offer(8'd9);
    step_chk("r9a", 1'b1, 1'b0);
    chk("r9a_rdy", 32'(div_ready), 32'd0);
    div_valid = 1'b0;
    reset_n   = 1'b0;
    step_chk("r9b", 1'b0, 1'b0);
    chk("r9b_cur", 32'(cur_div), 32'd3);
    chk("r9b_rdy", 32'(div_ready), 32'd1);
    reset_n = 1'b1;
    pat("r9c_", 4, 32'b1011, 32'b1001);
    chk("r9c_cur", 32'(cur_div), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
